uart_tx_arbiter: RTL and testbench

//  Shares one uart_tx transmitter between NUM_REQ byte requesters using round-robin arbitration.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_rr_pick.sv | 24 ++
 rtl/uart_tx_arbiter.sv | 133 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and arbiter FSM states
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_t;

  // Index width for n items, never below one bit so a single requester still has a port.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// rtl/uart_rr_pick.sv - combinational round-robin pick starting after ptr
module uart_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic               gnt_valid,
  output logic [IDW-1:0]     gnt_idx
);

  // Scan from the farthest offset down to ptr+1 so the nearest asserted request is the last write.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req[(int'(ptr) + k) % NUM_REQ]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IDW'((int'(ptr) + k) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin, packet-locking arbiter in front of one uart_tx
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int NUM_REQ      = 4,
  parameter  int LOCK_TIMEOUT = 1024,
  localparam int IDW          = idx_width(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [UART_DATA_W*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           tx_start,
  output logic [UART_DATA_W-1:0]         tx_data,
  input  logic                           tx_busy,
  output logic [IDW-1:0]                 grant_id,
  output logic                           locked,
  output logic                           lock_timeout
);

  localparam int PADN  = 1 << IDW;
  localparam int CNT_W = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;

  arb_state_t             state;
  arb_state_t             state_nxt;
  logic [IDW-1:0]         rr_ptr;
  logic [CNT_W-1:0]       idle_cnt;
  logic [PADN-1:0]        valid_pad;
  logic                   rr_valid;
  logic [IDW-1:0]         rr_idx;
  logic                   win_valid;
  logic [IDW-1:0]         win_idx;
  logic [UART_DATA_W-1:0] win_data;
  logic                   win_last;
  logic                   xfer;
  logic                   owner_idle;
  logic                   expire;

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_pick (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .gnt_valid (rr_valid),
    .gnt_idx   (rr_idx)
  );

  // Padded copy lets grant_id index valid without running past a non-power-of-two vector.
  assign valid_pad = PADN'(req_valid);

  // A held lock restricts the grant to its owner; otherwise the round-robin pick wins.
  // Granting only happens in IDLE with the transmitter free, and never while reset is applied.
  always_comb begin
    win_idx   = locked ? grant_id : rr_idx;
    win_valid = locked ? valid_pad[grant_id] : rr_valid;
    win_data  = '0;
    win_last  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDW'(i) == win_idx) begin
        win_data = req_data[i*UART_DATA_W +: UART_DATA_W];
        win_last = req_last[i];
      end
    end
    req_ready = '0;
    if (!rst && state == IDLE && !tx_busy && win_valid) begin
      req_ready = NUM_REQ'(1) << win_idx;
    end
  end

  assign xfer       = |(req_valid & req_ready);
  assign owner_idle = (state == IDLE) && locked && !valid_pad[grant_id];
  assign expire     = (LOCK_TIMEOUT > 0) && owner_idle &&
                      (idle_cnt == CNT_W'(LOCK_TIMEOUT - 1));

  // State register for the transmit sequencer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Sequencer: pulse start, wait for uart_tx to go busy, then wait for it to finish the frame.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (xfer)     state_nxt = START;
      START:                   state_nxt = WAIT_ACK;
      WAIT_ACK:  if (tx_busy)  state_nxt = WAIT_DONE;
      WAIT_DONE: if (!tx_busy) state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // Capture the accepted byte and owner; the lock follows req_last unless the idle timer expires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_start     <= 1'b0;
      tx_data      <= '0;
      grant_id     <= '0;
      locked       <= 1'b0;
      lock_timeout <= 1'b0;
      rr_ptr       <= IDW'(NUM_REQ - 1);
    end else begin
      tx_start     <= xfer;
      lock_timeout <= expire;
      if (xfer) begin
        tx_data  <= win_data;
        grant_id <= win_idx;
        rr_ptr   <= win_idx;
        locked   <= ~win_last;
      end else if (expire) begin
        locked   <= 1'b0;
      end
    end
  end

  // Idle timer for a held lock: counts IDLE cycles with the owner silent, cleared by any grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (xfer || !locked || expire) begin
      idle_cnt <= '0;
    end else if (owner_idle && LOCK_TIMEOUT > 0) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter with a behavioural uart_tx
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int LT = 8;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] d;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic           tx_busy;
  logic [1:0]     grant_id;
  logic           locked;
  logic           lock_timeout;

  uart_tx_arbiter #(.NUM_REQ(N), .LOCK_TIMEOUT(LT)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .tx_busy      (tx_busy),
    .grant_id     (grant_id),
    .locked       (locked),
    .lock_timeout (lock_timeout)
  );

  always #5 clk = ~clk;

  // Behavioural uart_tx: 8N1, one bit per baud tick (every 16 clk), not reset by rst.
  int         baud_cnt = 0;
  logic       u_busy   = 1'b0;
  logic [9:0] u_sh     = '1;
  int         u_n      = 0;
  logic       serial;
  assign tx_busy = u_busy;
  assign serial  = u_busy ? u_sh[0] : 1'b1;

  always @(posedge clk) begin
    baud_cnt <= (baud_cnt + 1) % 16;
    if (!u_busy) begin
      if (tx_start) begin
        u_busy <= 1'b1;
        u_sh   <= {1'b1, tx_data, 1'b0};
        u_n    <= 0;
      end
    end else if (baud_cnt == 15) begin
      if (u_n == 9) u_busy <= 1'b0;
      u_sh <= {1'b1, u_sh[9:1]};
      u_n  <= u_n + 1;
    end
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: arbiter availability, rotation pointer, lock owner and idle timer.
  int         m_ptr = N - 1;
  int         m_owner = 0;
  int         m_cnt = 0;
  bit         m_locked = 0;
  bit         m_avail = 1;
  bit         m_seen = 0;
  bit         m_start_due = 0;
  bit         m_pulse = 0;
  exp_t       expq[$];
  logic [7:0] serq[$];
  int         start_log[$];
  int         n_tmo = 0;
  bit         r_act = 0;
  int         r_n = 0;
  logic [7:0] r_sh = '0;

  always @(negedge clk) begin
    int         w;
    int         j;
    logic [3:0] exp_rdy;
    exp_t       e;
    if (rst) begin
      chk("reset_outputs", 32'({tx_start, tx_data, grant_id, locked, lock_timeout, req_ready}), 32'd0);
      m_ptr = N - 1; m_owner = 0; m_cnt = 0; m_locked = 0;
      m_avail = 1; m_seen = 0; m_start_due = 0; m_pulse = 0;
      expq.delete();
    end else begin
      chk("tx_start", 32'(tx_start), 32'(m_start_due));
      if (tx_start) begin
        start_log.push_back(int'(grant_id));
        if (expq.size() == 0) begin
          chk("tx_start_unexpected", 32'(tx_start), 32'd0);
        end else begin
          e = expq.pop_front();
          chk("tx_data", 32'(tx_data), 32'(e.d));
          chk("grant_id", 32'(grant_id), 32'(e.id));
        end
      end
      if (lock_timeout) n_tmo++;
      chk("lock_timeout", 32'(lock_timeout), 32'(m_pulse));
      chk("locked", 32'(locked), 32'(m_locked));

      w = -1;
      if (m_avail && !tx_busy) begin
        if (m_locked) begin
          if (req_valid[m_owner]) w = m_owner;
        end else begin
          for (int k = 1; k <= N; k++) begin
            j = (m_ptr + k) % N;
            if (w < 0 && req_valid[j]) w = j;
          end
        end
      end
      exp_rdy = (w >= 0) ? (4'b0001 << w) : 4'b0000;
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));

      m_start_due = 0;
      m_pulse     = 0;
      if (w >= 0) begin
        e.id = 2'(w);
        e.d  = req_data[w*8 +: 8];
        expq.push_back(e);
        serq.push_back(e.d);
        m_ptr = w; m_owner = w; m_locked = !req_last[w];
        m_cnt = 0; m_avail = 0; m_seen = 0; m_start_due = 1;
      end else if (!m_avail) begin
        if (tx_busy) m_seen = 1;
        else if (m_seen) m_avail = 1;
      end else if (m_locked && !req_valid[m_owner]) begin
        m_cnt++;
        if (m_cnt == LT) begin
          m_locked = 0; m_pulse = 1; m_cnt = 0;
        end
      end
      if (!m_locked) m_cnt = 0;
    end

    // Serial receiver: samples the line during the cycle that ends in a baud tick.
    if (baud_cnt == 15) begin
      if (!r_act) begin
        if (serial == 1'b0) begin r_act = 1; r_n = 0; end
      end else if (r_n < 8) begin
        r_sh = {serial, r_sh[7:1]};
        r_n++;
      end else begin
        r_act = 0;
        chk("stop_bit", 32'(serial), 32'd1);
        if (serq.size() == 0) chk("serial_unexpected", 32'(r_sh), 32'hFFFF_FFFF);
        else chk("serial_byte", 32'(r_sh), 32'(serq.pop_front()));
      end
    end
  end

  task automatic drive_byte(input int i, input logic [7:0] d, input logic l);
    int n;
    req_valid[i] = 1'b1;
    req_data[i*8 +: 8] = d;
    req_last[i] = l;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[i] && n < 4000);
    if (!req_ready[i]) chk("accept_timeout", 32'(req_ready[i]), 32'd1);
    @(posedge clk);
    #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(!tx_busy && m_avail && req_valid == '0) && n < 4000);
    if (n >= 4000) chk("idle_timeout", 32'(tx_busy), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic chk_log(input string name, input int n, input logic [31:0] exp);
    logic [31:0] act;
    act = '0;
    foreach (start_log[k]) act = (act << 4) | 32'(start_log[k] & 15);
    n_cmp++;
    if (start_log.size() != n || act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d grants order=%h, want %0d order=%h", name, start_log.size(), act, n, exp);
    end
  endtask

  task automatic rand_req(input int i);
    int len;
    int g;
    for (int p = 0; p < 6; p++) begin
      g = $urandom_range(0, 30);
      if (g > 0) begin repeat (g) @(posedge clk); #1; end
      len = $urandom_range(1, 3);
      for (int b = 0; b < len; b++) begin
        drive_byte(i, 8'($urandom), b == len - 1);
        if (b < len - 1 && $urandom_range(0, 3) == 0) begin
          g = $urandom_range(150, 260);
          repeat (g) @(posedge clk);
          #1;
        end
      end
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    start_log.delete();
    drive_byte(0, 8'hA5, 1'b1);
    wait_idle();
    chk_log("t1_single", 1, 32'h0);

    do_reset();
    start_log.delete();
    fork
      begin drive_byte(0, 8'h10, 1'b1); drive_byte(0, 8'h14, 1'b1); end
      drive_byte(1, 8'h11, 1'b1);
      drive_byte(2, 8'h12, 1'b1);
      drive_byte(3, 8'h13, 1'b1);
    join
    wait_idle();
    chk_log("t2_rotation", 5, 32'h01230);

    do_reset();
    start_log.delete();
    fork
      begin drive_byte(1, 8'hB1, 1'b0); drive_byte(1, 8'hB2, 1'b0); drive_byte(1, 8'hB3, 1'b1); end
      drive_byte(2, 8'hC2, 1'b1);
    join
    wait_idle();
    chk_log("t3_packet_lock", 4, 32'h1112);

    do_reset();
    start_log.delete();
    n_tmo = 0;
    fork
      drive_byte(1, 8'h41, 1'b0);
      begin repeat (5) @(posedge clk); #1; drive_byte(2, 8'h42, 1'b1); end
    join
    wait_idle();
    chk_log("t4_timeout_order", 2, 32'h12);
    chk("t4_timeout_pulses", 32'(n_tmo), 32'd1);

    start_log.delete();
    drive_byte(0, 8'h55, 1'b1);
    repeat (40) @(posedge clk);
    #1;
    chk("t5_mid_frame", 32'(tx_busy), 32'd1);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    drive_byte(3, 8'h5A, 1'b1);
    wait_idle();
    chk_log("t5_reset_mid_frame", 2, 32'h03);

    do_reset();
    start_log.delete();
    drive_byte(0, 8'h60, 1'b0);
    n_tmo = 0;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (m_cnt != LT - 1 && n < 1000);
    #1;
    drive_byte(0, 8'h61, 1'b0);
    chk("t6_locked_kept", 32'(locked), 32'd1);
    drive_byte(0, 8'h62, 1'b1);
    wait_idle();
    chk("t6_no_timeout", 32'(n_tmo), 32'd0);
    chk_log("t6_expiry_race", 3, 32'h000);

    do_reset();
    fork
      rand_req(0);
      rand_req(1);
      rand_req(2);
      rand_req(3);
    join
    wait_idle();
    chk("rand_expq_drained", 32'(expq.size()), 32'd0);
    chk("rand_serial_drained", 32'(serq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit, want completion");
    $fatal(1, "watchdog");
  end

endmodule
